ras_resolve: RTL and testbench
==============================

# ras_resolve

Execute-stage resolver for return-address-stack predictions. Fetch enqueues one entry per predicted call or return: the predicted target and the RAS stack-pointer snapshot taken before the push or pop. Execute resolves entries in program order against the actual jump target. On a mismatch the block raises a registered redirect, hands the RAS a corrected stack pointer, and discards all younger in-flight entries.

## Interface
- XLEN, 32, address width (matches `XLEN`)
- PTR_W, 3, RAS pointer width (matches `RAS_PTR_WIDTH`); pointer arithmetic is modulo 2^PTR_W
- DEPTH, 4, in-flight entry capacity; power of two, at least 2

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pred_valid  in  1  fetch offers an entry this cycle
- pred_is_call  in  1  entry is a call (RAS push); exclusive with pred_is_return
- pred_is_return  in  1  entry is a return (RAS pop)
- pred_target  in  XLEN  predicted target PC
- pred_ptr  in  PTR_W  RAS stack_ptr before this instruction's push or pop
- pred_ready  out  1  entry can be accepted (combinational, = !full)
- res_valid  in  1  execute resolves the oldest entry this cycle
- res_target  in  XLEN  actual jump target computed in execute
- res_ready  out  1  = !empty (combinational)
- flush  in  1  external pipeline flush; discard all entries
- mispredict  out  1  registered one-cycle pulse
- redirect_pc  out  XLEN  correct target; valid while mispredict = 1
- restore_en  out  1  registered pulse, coincident with mispredict
- restore_ptr  out  PTR_W  corrected RAS pointer; valid while restore_en = 1
- count  out  log2(DEPTH)+1  current occupancy
- mispredict_cnt  out  16  saturating count of mispredicts

## Operation
- Storage: circular FIFO of DEPTH entries {is_call, is_return, target, ptr}, with read pointer, write pointer and count.
- Enqueue occurs when pred_valid && pred_ready && (pred_is_call || pred_is_return). If both type bits are 0, nothing is enqueued.
- Resolve occurs when res_valid && res_ready. The oldest entry is popped and compared with res_target.
  - Match: no output activity.
  - Mismatch: next cycle mispredict = restore_en = 1 and redirect_pc = res_target.
  - restore_ptr is the pointer after this instruction's own RAS operation: entry.ptr + 1 for a call, entry.ptr − 1 for a return, both modulo 2^PTR_W. Wrap-around is legal and expected (ptr 7 call → 0; ptr 0 return → 7 with PTR_W = 3).
  - On a mismatch, all remaining (younger) entries are discarded and count becomes 0.
- Enqueue on the same cycle as a mismatching resolve: the new entry is dropped because it is wrong-path, and count becomes 0.
- Enqueue on the same cycle as a matching resolve: both take effect and count is unchanged. This is legal even when the FIFO is full only if pred_ready allowed it. pred_ready does not look at the same-cycle pop, so a full FIFO refuses the enqueue.
- Flush: all entries are discarded and count becomes 0. No mispredict or restore pulse is produced. Flush has priority over a same-cycle resolve and enqueue, both of which are ignored. A mispredict pulse already registered from the previous cycle still appears.
- res_valid while empty is ignored (res_ready = 0).
- pred_valid while full is ignored (pred_ready = 0). The fetch side must hold the entry until accepted.
- mispredict_cnt increments on each mispredict pulse and saturates at 0xFFFF.

## Timing
- Reset values: mispredict = 0, restore_en = 0, redirect_pc = 0, restore_ptr = 0, count = 0, mispredict_cnt = 0, pred_ready = 1, res_ready = 0. FIFO pointers are 0.
- Reset asserted mid-operation clears everything asynchronously. The first enqueue is possible on the first rising edge after reset deasserts.
- Resolve-to-mispredict latency: exactly 1 cycle. The pulse lasts 1 cycle.
- Back-to-back mispredicts are not possible, because the FIFO is empty after a mismatch. A new entry can be enqueued the cycle after a mismatch.
- Enqueue-to-resolvable latency: 1 cycle. res_ready rises the cycle after the first enqueue into an empty FIFO.
- count is registered and reflects the operations of the previous edge.

## Test plan
- Reset, then enqueue return with target 0x100, ptr 3; resolve with res_target 0x100 → no mispredict; count goes 1 → 0.
- Enqueue return with target 0x100, ptr 3; resolve with 0x200 → next cycle mispredict = 1, redirect_pc = 0x200, restore_ptr = 2; mispredict_cnt = 1.
- Enqueue call ptr 7, return ptr 0, call ptr 7. Resolve the first entry with a mismatch → restore_ptr = 0 (wrap) and count = 0. A same-cycle enqueue is dropped.
- Fill 4 entries → pred_ready = 0 and a 5th pred_valid is ignored. Resolve with a match alongside pred_valid → count = 3, with no enqueue because the FIFO was full at decision time.
- Enqueue 2 entries, then flush together with a mismatching res_valid → count = 0 and no mispredict pulse. Repeat with flush one cycle after the mismatch → the pulse still appears.
- Force 65540 mismatches → mispredict_cnt holds at 0xFFFF. Assert reset mid-stream → all outputs take their reset values without a clock edge.

Source files
------------

// File: rtl/ras_resolve_if.sv
// Fetch/execute handshake bundle for the RAS prediction resolver.
interface ras_resolve_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             pred_valid;
  logic             pred_is_call;
  logic             pred_is_return;
  logic [XLEN-1:0]  pred_target;
  logic [PTR_W-1:0] pred_ptr;
  logic             pred_ready;
  logic             res_valid;
  logic [XLEN-1:0]  res_target;
  logic             res_ready;
  logic             flush;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic             restore_en;
  logic [PTR_W-1:0] restore_ptr;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output pred_valid, pred_is_call, pred_is_return, pred_target, pred_ptr,
    output res_valid, res_target, flush,
    input  pred_ready, res_ready, mispredict, redirect_pc, restore_en,
    input  restore_ptr, count, mispredict_cnt
  );

  modport slave (
    input  pred_valid, pred_is_call, pred_is_return, pred_target, pred_ptr,
    input  res_valid, res_target, flush,
    output pred_ready, res_ready, mispredict, redirect_pc, restore_en,
    output restore_ptr, count, mispredict_cnt
  );
endinterface

// File: rtl/ras_resolve.sv
// In-order resolver for RAS call/return predictions: FIFO of in-flight
// entries, compared at execute; mismatches redirect and restore the RAS pointer.
module ras_resolve #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  ras_resolve_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic             is_call;
    logic             is_return;
    logic [XLEN-1:0]  target;
    logic [PTR_W-1:0] ptr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             mis_q;
  logic             ren_q;
  logic [XLEN-1:0]  redirect_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] mcnt_q;

  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  logic             miss;
  entry_t           head;
  logic [PTR_W-1:0] fix_ptr;

  // Handshake decode and pointer fix-up for the oldest entry
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    enq     = bus.pred_valid && !full && (bus.pred_is_call || bus.pred_is_return);
    deq     = bus.res_valid && !empty;
    head    = mem[rd_ptr];
    miss    = deq && (head.target != bus.res_target);
    fix_ptr = head.ptr;
    if (head.is_call)        fix_ptr = head.ptr + PTR_W'(1);
    else if (head.is_return) fix_ptr = head.ptr - PTR_W'(1);
  end

  assign bus.pred_ready     = !full;
  assign bus.res_ready      = !empty;
  assign bus.count          = count_q;
  assign bus.mispredict     = mis_q;
  assign bus.restore_en     = ren_q;
  assign bus.redirect_pc    = redirect_q;
  assign bus.restore_ptr    = rptr_q;
  assign bus.mispredict_cnt = mcnt_q;

  // Entry storage needs no reset: pointers and count gate every read
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{bus.pred_is_call, bus.pred_is_return, bus.pred_target, bus.pred_ptr};
  end

  // Flush beats resolve; a mismatch empties the queue and drops any same-cycle enqueue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      mis_q      <= 1'b0;
      ren_q      <= 1'b0;
      redirect_q <= '0;
      rptr_q     <= '0;
      mcnt_q     <= '0;
    end else begin
      mis_q <= 1'b0;
      ren_q <= 1'b0;
      if (bus.flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else if (miss) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count_q    <= '0;
        mis_q      <= 1'b1;
        ren_q      <= 1'b1;
        redirect_q <= bus.res_target;
        rptr_q     <= fix_ptr;
        if (!(&mcnt_q)) mcnt_q <= mcnt_q + CNT_W'(1);
      end else begin
        if (enq) wr_ptr <= wr_ptr + AW'(1);
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        case ({enq, deq})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ras_resolve.sv
// Directed vector bench for ras_resolve, plus a narrow-counter twin for saturation.
module tb_ras_resolve;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ras_resolve_if bus_m ();
  ras_resolve_if #(.CNT_W(4)) bus_s ();

  assign bus_s.pred_valid     = bus_m.pred_valid;
  assign bus_s.pred_is_call   = bus_m.pred_is_call;
  assign bus_s.pred_is_return = bus_m.pred_is_return;
  assign bus_s.pred_target    = bus_m.pred_target;
  assign bus_s.pred_ptr       = bus_m.pred_ptr;
  assign bus_s.res_valid      = bus_m.res_valid;
  assign bus_s.res_target     = bus_m.res_target;
  assign bus_s.flush          = bus_m.flush;

  ras_resolve u_dut (.clk(clk), .reset(reset), .bus(bus_m));
  ras_resolve #(.CNT_W(4)) u_small (.clk(clk), .reset(reset), .bus(bus_s));

  typedef struct {
    logic        pv;
    logic        call;
    logic        ret;
    logic [31:0] tgt;
    logic [2:0]  ptr;
    logic        rv;
    logic [31:0] rtgt;
    logic        fl;
    logic        e_mis;
    logic [31:0] e_pc;
    logic [2:0]  e_rptr;
    logic [2:0]  e_cnt;
    logic [15:0] e_mcnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic pv, logic call, logic ret, logic [31:0] tgt, logic [2:0] ptr,
                             logic rv, logic [31:0] rtgt, logic fl, logic e_mis, logic [31:0] e_pc,
                             logic [2:0] e_rptr, logic [2:0] e_cnt, logic [15:0] e_mcnt);
    vec_t r;
    r.pv = pv; r.call = call; r.ret = ret; r.tgt = tgt; r.ptr = ptr;
    r.rv = rv; r.rtgt = rtgt; r.fl = fl; r.e_mis = e_mis; r.e_pc = e_pc;
    r.e_rptr = e_rptr; r.e_cnt = e_cnt; r.e_mcnt = e_mcnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_m.pred_valid = 1'b0; bus_m.pred_is_call = 1'b0; bus_m.pred_is_return = 1'b0;
    bus_m.pred_target = '0; bus_m.pred_ptr = '0;
    bus_m.res_valid = 1'b0; bus_m.res_target = '0; bus_m.flush = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " mispredict"}, 64'(bus_m.mispredict), 64'd0);
    chk({tag, " restore_en"}, 64'(bus_m.restore_en), 64'd0);
    chk({tag, " redirect_pc"}, 64'(bus_m.redirect_pc), 64'd0);
    chk({tag, " restore_ptr"}, 64'(bus_m.restore_ptr), 64'd0);
    chk({tag, " count"}, 64'(bus_m.count), 64'd0);
    chk({tag, " mispredict_cnt"}, 64'(bus_m.mispredict_cnt), 64'd0);
    chk({tag, " pred_ready"}, 64'(bus_m.pred_ready), 64'd1);
    chk({tag, " res_ready"}, 64'(bus_m.res_ready), 64'd0);
    chk({tag, " small mispredict_cnt"}, 64'(bus_s.mispredict_cnt), 64'd0);
  endtask

  initial begin
    logic [3:0] s_mcnt;
    //        pv call ret tgt     ptr rv rtgt    fl mis pc      rptr cnt mcnt
    vq.push_back(v(1, 0, 1, 32'h100, 3, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 1, 32'h100, 0, 0, 32'h0,   0, 0, 0));
    vq.push_back(v(1, 0, 1, 32'h100, 3, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 1, 32'h200, 0, 1, 32'h200, 2, 0, 1));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 1));
    vq.push_back(v(1, 1, 0, 32'h10,  7, 0, 32'h0,   0, 0, 32'h0,   0, 1, 1));
    vq.push_back(v(1, 0, 1, 32'h20,  0, 0, 32'h0,   0, 0, 32'h0,   0, 2, 1));
    vq.push_back(v(1, 1, 0, 32'h30,  7, 0, 32'h0,   0, 0, 32'h0,   0, 3, 1));
    vq.push_back(v(1, 0, 1, 32'h40,  5, 1, 32'h11,  0, 1, 32'h11,  0, 0, 2));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 2));
    vq.push_back(v(1, 0, 1, 32'h50,  0, 0, 32'h0,   0, 0, 32'h0,   0, 1, 2));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 1, 32'h51,  0, 1, 32'h51,  7, 0, 3));
    vq.push_back(v(1, 1, 0, 32'h60,  1, 0, 32'h0,   0, 0, 32'h0,   0, 1, 3));
    vq.push_back(v(1, 0, 1, 32'h61,  2, 0, 32'h0,   0, 0, 32'h0,   0, 2, 3));
    vq.push_back(v(1, 1, 0, 32'h62,  1, 0, 32'h0,   0, 0, 32'h0,   0, 3, 3));
    vq.push_back(v(1, 0, 1, 32'h63,  2, 0, 32'h0,   0, 0, 32'h0,   0, 4, 3));
    vq.push_back(v(1, 1, 0, 32'h70,  4, 0, 32'h0,   0, 0, 32'h0,   0, 4, 3));
    vq.push_back(v(1, 1, 0, 32'h70,  4, 1, 32'h60,  0, 0, 32'h0,   0, 3, 3));
    vq.push_back(v(1, 0, 0, 32'h77,  4, 0, 32'h0,   0, 0, 32'h0,   0, 3, 3));
    vq.push_back(v(1, 1, 0, 32'h71,  3, 1, 32'h61,  0, 0, 32'h0,   0, 3, 3));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 1, 32'h62,  0, 0, 32'h0,   0, 2, 3));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 1, 32'h63,  0, 0, 32'h0,   0, 1, 3));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 1, 32'h71,  0, 0, 32'h0,   0, 0, 3));
    vq.push_back(v(1, 1, 0, 32'h80,  1, 0, 32'h0,   0, 0, 32'h0,   0, 1, 3));
    vq.push_back(v(1, 0, 1, 32'h81,  2, 0, 32'h0,   0, 0, 32'h0,   0, 2, 3));
    vq.push_back(v(1, 1, 0, 32'h82,  2, 1, 32'h99,  1, 0, 32'h0,   0, 0, 3));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 3));
    vq.push_back(v(1, 1, 0, 32'h90,  6, 0, 32'h0,   0, 0, 32'h0,   0, 1, 3));
    vq.push_back(v(1, 0, 1, 32'h91,  6, 0, 32'h0,   0, 0, 32'h0,   0, 2, 3));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 1, 32'h95,  0, 1, 32'h95,  7, 0, 4));
    vq.push_back(v(0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h0,   0, 0, 4));

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_state("por");

    for (int i = 0; i < vq.size(); i++) begin
      bus_m.pred_valid = vq[i].pv; bus_m.pred_is_call = vq[i].call; bus_m.pred_is_return = vq[i].ret;
      bus_m.pred_target = vq[i].tgt; bus_m.pred_ptr = vq[i].ptr;
      bus_m.res_valid = vq[i].rv; bus_m.res_target = vq[i].rtgt; bus_m.flush = vq[i].fl;
      step();
      s_mcnt = (vq[i].e_mcnt > 16'd15) ? 4'hF : vq[i].e_mcnt[3:0];
      chk($sformatf("v%0d mispredict", i), 64'(bus_m.mispredict), 64'(vq[i].e_mis));
      chk($sformatf("v%0d restore_en", i), 64'(bus_m.restore_en), 64'(vq[i].e_mis));
      if (vq[i].e_mis) begin
        chk($sformatf("v%0d redirect_pc", i), 64'(bus_m.redirect_pc), 64'(vq[i].e_pc));
        chk($sformatf("v%0d restore_ptr", i), 64'(bus_m.restore_ptr), 64'(vq[i].e_rptr));
        chk($sformatf("v%0d small redirect_pc", i), 64'(bus_s.redirect_pc), 64'(vq[i].e_pc));
        chk($sformatf("v%0d small restore_ptr", i), 64'(bus_s.restore_ptr), 64'(vq[i].e_rptr));
      end
      chk($sformatf("v%0d count", i), 64'(bus_m.count), 64'(vq[i].e_cnt));
      chk($sformatf("v%0d mispredict_cnt", i), 64'(bus_m.mispredict_cnt), 64'(vq[i].e_mcnt));
      chk($sformatf("v%0d pred_ready", i), 64'(bus_m.pred_ready), 64'(vq[i].e_cnt != 3'd4));
      chk($sformatf("v%0d res_ready", i), 64'(bus_m.res_ready), 64'(vq[i].e_cnt != 3'd0));
      chk($sformatf("v%0d small mispredict", i), 64'(bus_s.mispredict), 64'(vq[i].e_mis));
      chk($sformatf("v%0d small restore_en", i), 64'(bus_s.restore_en), 64'(vq[i].e_mis));
      chk($sformatf("v%0d small count", i), 64'(bus_s.count), 64'(vq[i].e_cnt));
      chk($sformatf("v%0d small pred_ready", i), 64'(bus_s.pred_ready), 64'(vq[i].e_cnt != 3'd4));
      chk($sformatf("v%0d small res_ready", i), 64'(bus_s.res_ready), 64'(vq[i].e_cnt != 3'd0));
      chk($sformatf("v%0d small mispredict_cnt", i), 64'(bus_s.mispredict_cnt), 64'(s_mcnt));
    end
    idle_inputs();

    // 20 back-to-back mismatches: wide counter 4 -> 24, 4-bit twin pins at 0xF
    for (int k = 0; k < 20; k++) begin
      bus_m.pred_valid = 1'b1; bus_m.pred_is_call = 1'b1; bus_m.pred_target = 32'h0; bus_m.pred_ptr = 3'd0;
      step();
      bus_m.pred_valid = 1'b0; bus_m.pred_is_call = 1'b0;
      bus_m.res_valid = 1'b1; bus_m.res_target = 32'h1;
      step();
      bus_m.res_valid = 1'b0;
      chk($sformatf("sat%0d pulse", k), 64'(bus_m.mispredict), 64'd1);
      if (k == 10) chk("sat small at 15", 64'(bus_s.mispredict_cnt), 64'hF);
    end
    chk("sat wide cnt", 64'(bus_m.mispredict_cnt), 64'd24);
    chk("sat small held", 64'(bus_s.mispredict_cnt), 64'hF);

    // Async reset while a mispredict pulse is visible
    bus_m.pred_valid = 1'b1; bus_m.pred_is_call = 1'b1; bus_m.pred_target = 32'h5; bus_m.pred_ptr = 3'd2;
    step();
    bus_m.pred_valid = 1'b0; bus_m.pred_is_call = 1'b0;
    bus_m.res_valid = 1'b1; bus_m.res_target = 32'h6;
    step();
    bus_m.res_valid = 1'b0;
    chk("pre-reset pulse", 64'(bus_m.mispredict), 64'd1);
    chk("pre-reset restore_ptr", 64'(bus_m.restore_ptr), 64'd3);
    #2 reset = 1'b1;
    #1 chk_reset_state("async1");
    reset = 1'b0;
    bus_m.pred_valid = 1'b1; bus_m.pred_is_return = 1'b1; bus_m.pred_target = 32'h7; bus_m.pred_ptr = 3'd1;
    step();
    bus_m.pred_valid = 1'b0; bus_m.pred_is_return = 1'b0;
    chk("post-reset first enq count", 64'(bus_m.count), 64'd1);
    chk("post-reset res_ready", 64'(bus_m.res_ready), 64'd1);
    #2 reset = 1'b1;
    #1 chk_reset_state("async2");
    reset = 1'b0;
    step();
    chk("after async2 count", 64'(bus_m.count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
